// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// one-hot result encoding ordered as {smaller, equal, greater}.
package seq_magnitude_comparator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef logic [2:0] result_t;

  localparam result_t RESULT_NONE = 3'b000;
  localparam result_t SMALLER     = 3'b100;
  localparam result_t EQUAL       = 3'b010;
  localparam result_t GREATER     = 3'b001;

endpackage

// File: rtl/seq_magnitude_comparator_cmp_digit.sv
// Combinational unsigned comparison of one DIGIT-bit chunk.
module cmp_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Compares a and b one DIGIT-bit chunk per cycle, MSB chunk first, stopping
// at the first differing chunk; signed mode flips the sign bits on capture.
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             smaller,
  output logic             equal,
  output logic             greater
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t          state, state_next;
  logic [IW-1:0]   idx, idx_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  result_t         result, result_next;
  logic            done_next;
  logic            load;

  logic [DIGIT-1:0] a_chunks [N];
  logic [DIGIT-1:0] b_chunks [N];
  logic             chunk_lt, chunk_eq, chunk_gt;

  for (genvar i = 0; i < N; i++) begin : g_chunks
    assign a_chunks[i] = a_reg[i*DIGIT +: DIGIT];
    assign b_chunks[i] = b_reg[i*DIGIT +: DIGIT];
  end

  cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
    .a  (a_chunks[idx]),
    .b  (b_chunks[idx]),
    .lt (chunk_lt),
    .eq (chunk_eq),
    .gt (chunk_gt)
  );

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    result_next = result;
    done_next   = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          idx_next   = LAST_IDX;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (!chunk_eq) begin
          result_next = chunk_lt ? SMALLER : (chunk_gt ? GREATER : result);
          done_next   = 1'b1;
          state_next  = IDLE;
        end else if (idx == '0) begin
          result_next = EQUAL;
          done_next   = 1'b1;
          state_next  = IDLE;
        end else begin
          idx_next = idx - IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign-bit flip maps two's-complement order onto plain unsigned order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= RESULT_NONE;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      result <= result_next;
      done   <= done_next;
      if (load) begin
        a_reg <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
        b_reg <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
      end
    end
  end

  assign busy = (state == SCAN);
  assign {smaller, equal, greater} = result;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator with DIGIT=1 and DIGIT=4
// instances sharing the same stimulus.
module tb_seq_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic busy1, done1, smaller1, equal1, greater1;
  logic busy4, done4, smaller4, equal4, greater4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy1), .done(done1),
    .smaller(smaller1), .equal(equal1), .greater(greater1)
  );

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy4), .done(done4),
    .smaller(smaller4), .equal(equal4), .greater(greater4)
  );

  // Result vectors are {smaller, equal, greater}.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic sm);
    a = av;
    b = bv;
    signed_mode = sm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the negedge right after the accept edge; k = cycles until done.
  task automatic wait_done(input bit use4, output int k);
    k = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ((use4 ? done4 : done1) === 1'b1) begin
        k = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy1, done1, smaller1, equal1, greater1} !== 5'b0)
      $display("FAIL reset_dut1: got %b expected 00000", {busy1, done1, smaller1, equal1, greater1});
    else passed++;
    total++;
    if ({busy4, done4, smaller4, equal4, greater4} !== 5'b0)
      $display("FAIL reset_dut4: got %b expected 00000", {busy4, done4, smaller4, equal4, greater4});
    else passed++;
    start = 1'b1;
    a = 8'h01;
    b = 8'h02;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    total++;
    if (busy1 !== 1'b0)
      $display("FAIL reset_release_no_start: busy got %b expected 0", busy1);
    else passed++;
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({busy1, done1} !== 2'b00)
      $display("FAIL reset_release_idle: busy,done got %b expected 00", {busy1, done1});
    else passed++;
  endtask

  task automatic test_unsigned();
    int k;
    issue(8'h80, 8'h7F, 1'b0);
    wait_done(1'b0, k);
    total++;
    if (k !== 1) $display("FAIL unsigned_latency: got %0d expected 1", k);
    else passed++;
    total++;
    if ({smaller1, equal1, greater1} !== 3'b001)
      $display("FAIL unsigned_result: got %b expected 001", {smaller1, equal1, greater1});
    else passed++;
    @(negedge clk);
    total++;
    if (done1 !== 1'b0) $display("FAIL unsigned_done_width: got %b expected 0", done1);
    else passed++;
    total++;
    if ({smaller1, equal1, greater1} !== 3'b001)
      $display("FAIL unsigned_hold: got %b expected 001", {smaller1, equal1, greater1});
    else passed++;
  endtask

  task automatic test_signed();
    int k;
    issue(8'h80, 8'h7F, 1'b1);
    wait_done(1'b0, k);
    total++;
    if (k !== 1) $display("FAIL signed_latency: got %0d expected 1", k);
    else passed++;
    total++;
    if ({smaller1, equal1, greater1} !== 3'b100)
      $display("FAIL signed_result: got %b expected 100", {smaller1, equal1, greater1});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k;
    int busy_cycles;
    int hold_errors;
    a = 8'hA5;
    b = 8'hA5;
    signed_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    hold_errors = 0;
    k = -1;
    for (int c = 0; c <= 40; c++) begin
      if (busy1 === 1'b1) busy_cycles++;
      if (busy1 === 1'b1 && {smaller1, equal1, greater1} !== 3'b100) hold_errors++;
      if (done1 === 1'b1) begin
        k = c;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (k !== 8) $display("FAIL equal_latency: got %0d expected 8", k);
    else passed++;
    total++;
    if (busy_cycles !== 8) $display("FAIL equal_busy_cycles: got %0d expected 8", busy_cycles);
    else passed++;
    total++;
    if (hold_errors !== 0) $display("FAIL result_hold_while_busy: got %0d changes expected 0", hold_errors);
    else passed++;
    total++;
    if ({smaller1, equal1, greater1} !== 3'b010)
      $display("FAIL equal_result: got %b expected 010", {smaller1, equal1, greater1});
    else passed++;
    issue(8'h12, 8'h13, 1'b0);
    total++;
    if (busy1 !== 1'b1) $display("FAIL back_to_back_accept: busy got %b expected 1", busy1);
    else passed++;
    wait_done(1'b0, k);
    total++;
    if (k !== 8) $display("FAIL back_to_back_latency: got %0d expected 8", k);
    else passed++;
    total++;
    if ({smaller1, equal1, greater1} !== 3'b100)
      $display("FAIL back_to_back_result: got %b expected 100", {smaller1, equal1, greater1});
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_digit4();
    int k;
    issue(8'h3C, 8'h3D, 1'b0);
    wait_done(1'b1, k);
    total++;
    if (k !== 2) $display("FAIL digit4_smaller_latency: got %0d expected 2", k);
    else passed++;
    total++;
    if ({smaller4, equal4, greater4} !== 3'b100)
      $display("FAIL digit4_smaller_result: got %b expected 100", {smaller4, equal4, greater4});
    else passed++;
    @(negedge clk);
    issue(8'h4C, 8'h3C, 1'b0);
    wait_done(1'b1, k);
    total++;
    if (k !== 1) $display("FAIL digit4_greater_latency: got %0d expected 1", k);
    else passed++;
    total++;
    if ({smaller4, equal4, greater4} !== 3'b001)
      $display("FAIL digit4_greater_result: got %b expected 001", {smaller4, equal4, greater4});
    else passed++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int pulses;
    int first_done;
    issue(8'h55, 8'h54, 1'b0);
    pulses = 0;
    first_done = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
      end
      if (c == 3) start = 1'b0;
      @(negedge clk);
      if (done1 === 1'b1) begin
        pulses++;
        if (first_done < 0) first_done = c;
      end
    end
    total++;
    if (pulses !== 1) $display("FAIL ignore_start_pulses: got %0d expected 1", pulses);
    else passed++;
    total++;
    if (first_done !== 8) $display("FAIL ignore_start_latency: got %0d expected 8", first_done);
    else passed++;
    total++;
    if ({smaller1, equal1, greater1} !== 3'b001)
      $display("FAIL ignore_start_result: got %b expected 001", {smaller1, equal1, greater1});
    else passed++;
  endtask

  task automatic test_reset_abort();
    int k;
    int pulses;
    issue(8'hA5, 8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy1, done1, smaller1, equal1, greater1} !== 5'b0)
      $display("FAIL reset_abort_immediate: got %b expected 00000", {busy1, done1, smaller1, equal1, greater1});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done1 === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL reset_abort_no_done: got %0d pulses expected 0", pulses);
    else passed++;
    issue(8'h01, 8'h02, 1'b0);
    wait_done(1'b0, k);
    total++;
    if (k !== 7) $display("FAIL after_reset_latency: got %0d expected 7", k);
    else passed++;
    total++;
    if ({smaller1, equal1, greater1} !== 3'b100)
      $display("FAIL after_reset_result: got %b expected 100", {smaller1, equal1, greater1});
    else passed++;
  endtask

  initial begin
    #3;
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_digit4();
    test_ignore_start();
    test_reset_abort();
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter DIGIT, default 1, bits compared per cycle (WIDTH divisible by DIGIT).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a request to begin a comparison.
REQ-006 The block SHALL have port signed_mode, input, 1 bit, which selects two's-complement comparison when 1 and unsigned when 0.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each, the operands.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a comparison is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a new valid result.
REQ-010 The block SHALL have ports smaller, equal and greater, output, 1 bit each, the registered result of a relative to b.

Function
REQ-011 The FSM SHALL have two states, IDLE and SCAN, with N = WIDTH/DIGIT chunks.
REQ-012 In IDLE, start=1 SHALL accept the request: capture a, b and signed_mode, set the chunk index to N-1 (MSB chunk), enter SCAN and set busy=1 at that edge.
REQ-013 On capture, bit WIDTH-1 of each operand SHALL be XORed with signed_mode so that a plain unsigned compare yields the signed ordering.
REQ-014 Each SCAN cycle SHALL compare exactly one DIGIT-bit chunk, MSB chunk first.
REQ-015 On the first unequal chunk, the block SHALL register smaller or greater, pulse done, clear busy and return to IDLE at that edge (early termination).
REQ-016 If chunk 0 is equal, the block SHALL register equal=1, pulse done and return to IDLE.
REQ-017 Latency SHALL be k cycles from the start-accept edge to the done-high cycle, where k = 1 + (N-1 - index of the first differing chunk), or N when all chunks are equal.
REQ-018 The outputs smaller, equal and greater SHALL be one-hot from the first done onward.
REQ-019 The result SHALL hold its value until the next result is written.
REQ-020 The result SHALL NOT change while busy=1.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 Operand changes during SCAN SHALL have no effect on the comparison in progress.
REQ-023 start=1 in the cycle where done=1 SHALL be accepted, since the state is IDLE, giving back-to-back operation with no dead cycle.
REQ-024 done SHALL be high for exactly one cycle per accepted request.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force IDLE, busy=0, done=0 and smaller=equal=greater=0, regardless of the clock.
REQ-026 A reset during SCAN SHALL abort the comparison with no done pulse.
REQ-027 After reset, the first start SHALL behave as a fresh request.
REQ-028 Reset release SHALL NOT start a comparison even if start=1; start is sampled only at clock edges with rst_n=1.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, SCAN) and the result encoding constants (SMALLER, EQUAL, GREATER).
REQ-030 One combinational sub-module, cmp_digit, parametrised by DIGIT, SHALL produce the lt, eq and gt outputs for one chunk.
REQ-031 The top level SHALL contain the FSM, the operand registers, the chunk index counter and the result registers.

Verification
REQ-032 WIDTH=8, DIGIT=1, signed_mode=0, a=0x80, b=0x7F, start pulse -> greater=1, done one cycle after the accept edge (k=1).
REQ-033 Same operands with signed_mode=1 -> smaller=1, k=1.
REQ-034 a=b=0xA5 -> equal=1, k=8, busy high for 8 cycles; then a=0x12, b=0x13 issued in the done cycle -> accepted, smaller=1, k=8.
REQ-035 WIDTH=8, DIGIT=4, a=0x3C, b=0x3D -> smaller=1, k=2; a=0x4C, b=0x3C -> greater=1, k=1.
REQ-036 start re-asserted with new operands during SCAN -> ignored, original result delivered, exactly one done pulse.
REQ-037 rst_n driven low mid-SCAN between clock edges -> busy, done and all result outputs go to 0 immediately, no done pulse, next start completes normally.
